// File: rtl/dmem_arbiter_if.sv
// Two-requester data memory bus: requester handshakes plus memory port.
// Environment side uses master; arbiter uses slave.
interface dmem_arbiter_if;
    logic        m0_req_i;
    logic        m0_we_i;
    logic [31:0] m0_addr_i;
    logic [31:0] m0_wdata_i;
    logic        m0_gnt_o;
    logic        m0_rvalid_o;
    logic [31:0] m0_rdata_o;
    logic        m0_err_o;

    logic        m1_req_i;
    logic        m1_we_i;
    logic [31:0] m1_addr_i;
    logic [31:0] m1_wdata_i;
    logic        m1_gnt_o;
    logic        m1_rvalid_o;
    logic [31:0] m1_rdata_o;
    logic        m1_err_o;

    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_rdata_i;

    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
        input  mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o,
        output mem_rdata_i
    );

    modport slave (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
        output mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o,
        input  mem_rdata_i
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one word-wide data memory between two requesters.
// One access per grant cycle; response registered one cycle later.
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 32,
    parameter bit          RR_INIT   = 1'b1
) (
    input logic         clk_i,
    input logic         rst_i,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    state_t      state;
    logic        last_grant;
    logic        active;
    logic        legal;
    logic        go;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    logic        m0_rvalid, m1_rvalid;
    logic        m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;

    always_comb begin
        active    = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        case (state)
            G0: begin
                active    = 1'b1;
                sel_we    = bus.m0_we_i;
                sel_addr  = bus.m0_addr_i;
                sel_wdata = bus.m0_wdata_i;
            end
            G1: begin
                active    = 1'b1;
                sel_we    = bus.m1_we_i;
                sel_addr  = bus.m1_addr_i;
                sel_wdata = bus.m1_wdata_i;
            end
            default: ;
        endcase
    end

    assign legal = (sel_addr[1:0] == 2'b00) && (sel_addr <= LAST_WORD);
    // Reset masks the strobes so a grant in flight can never write memory.
    assign go    = active & legal & ~rst_i;

    assign bus.mem_write_o = go & sel_we;
    assign bus.mem_read_o  = go & ~sel_we;
    assign bus.mem_addr_o  = go ? sel_addr : '0;
    assign bus.mem_wdata_o = go ? sel_wdata : '0;

    assign bus.m0_gnt_o    = (state == G0) & ~rst_i;
    assign bus.m1_gnt_o    = (state == G1) & ~rst_i;
    assign bus.m0_rvalid_o = m0_rvalid;
    assign bus.m1_rvalid_o = m1_rvalid;
    assign bus.m0_err_o    = m0_err;
    assign bus.m1_err_o    = m1_err;
    assign bus.m0_rdata_o  = m0_rdata;
    assign bus.m1_rdata_o  = m1_rdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_grant <= RR_INIT;
            m0_rvalid  <= 1'b0;
            m1_rvalid  <= 1'b0;
            m0_err     <= 1'b0;
            m1_err     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            m0_rvalid <= (state == G0);
            m1_rvalid <= (state == G1);
            m0_err    <= (state == G0) & ~legal;
            m1_err    <= (state == G1) & ~legal;
            if (state == G0)
                m0_rdata <= (legal & ~sel_we) ? bus.mem_rdata_i : '0;
            if (state == G1)
                m1_rdata <= (legal & ~sel_we) ? bus.mem_rdata_i : '0;

            case (state)
                IDLE: begin
                    // last_grant == 1 means m1 was served last, so m0 wins a tie.
                    if (bus.m0_req_i && bus.m1_req_i)
                        state <= last_grant ? G0 : G1;
                    else if (bus.m0_req_i)
                        state <= G0;
                    else if (bus.m1_req_i)
                        state <= G1;
                end
                G0: begin
                    last_grant <= 1'b0;
                    state      <= bus.m1_req_i ? G1 : IDLE;
                end
                G1: begin
                    last_grant <= 1'b1;
                    state      <= bus.m0_req_i ? G0 : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 32-byte little-endian memory model.
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    logic mem_init;
    int   n_tests;
    int   n_fail;

    logic [7:0] mem [32];

    dmem_arbiter_if bus ();

    dmem_arbiter #(
        .MEM_BYTES(32),
        .RR_INIT(1'b1)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            8:  return 8'h44;
            9:  return 8'h33;
            10: return 8'h22;
            11: return 8'h11;
            12: return 8'h78;
            13: return 8'h56;
            14: return 8'h34;
            15: return 8'h12;
            default: return 8'hA0 + 8'(i);
        endcase
    endfunction

    function automatic logic [31:0] memword(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    always_comb begin
        bus.mem_rdata_i = '0;
        if (bus.mem_addr_o <= 32'd28)
            bus.mem_rdata_i = memword(int'(bus.mem_addr_o[4:0]));
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++)
                mem[i] <= init_byte(i);
        end else if (bus.mem_write_o && bus.mem_addr_o <= 32'd28) begin
            mem[int'(bus.mem_addr_o[4:0])]     <= bus.mem_wdata_o[7:0];
            mem[int'(bus.mem_addr_o[4:0]) + 1] <= bus.mem_wdata_o[15:8];
            mem[int'(bus.mem_addr_o[4:0]) + 2] <= bus.mem_wdata_o[23:16];
            mem[int'(bus.mem_addr_o[4:0]) + 3] <= bus.mem_wdata_o[31:24];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // m1 issues one illegal write and must get err with no memory strobe.
    task automatic ill_write(input logic [31:0] addr, input int chk_a,
                             input logic [31:0] chk_w);
        bus.m1_req_i   = 1'b1;
        bus.m1_we_i    = 1'b1;
        bus.m1_addr_i  = addr;
        bus.m1_wdata_i = 32'hCAFEBABE;
        step();
        mid();
        check("ill_gnt1", 32'(bus.m1_gnt_o), 32'd1);
        check("ill_wr", 32'(bus.mem_write_o), 32'd0);
        check("ill_addr", bus.mem_addr_o, 32'h0);
        step();
        bus.m1_req_i = 1'b0;
        mid();
        check("ill_rvalid", 32'(bus.m1_rvalid_o), 32'd1);
        check("ill_err", 32'(bus.m1_err_o), 32'd1);
        check("ill_rdata", bus.m1_rdata_o, 32'h0);
        step();
        check("ill_mem", memword(chk_a), chk_w);
    endtask

    int n_g0;
    int n_g1;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        n_g0    = 0;
        n_g1    = 0;
        rst = 1'b1;
        mem_init = 1'b1;
        bus.m0_req_i = 1'b0; bus.m0_we_i = 1'b0;
        bus.m0_addr_i = '0;  bus.m0_wdata_i = '0;
        bus.m1_req_i = 1'b0; bus.m1_we_i = 1'b0;
        bus.m1_addr_i = '0;  bus.m1_wdata_i = '0;

        // Reset state
        step();
        mem_init = 1'b0;
        mid();
        check("rst_gnt0", 32'(bus.m0_gnt_o), 32'd0);
        check("rst_rvalid0", 32'(bus.m0_rvalid_o), 32'd0);
        check("rst_rdata0", bus.m0_rdata_o, 32'h0);
        check("rst_rdata1", bus.m1_rdata_o, 32'h0);
        step();
        rst = 1'b0;
        mid();
        check("post_rst_gnt", 32'({bus.m0_gnt_o, bus.m1_gnt_o}), 32'd0);
        step();

        // Single read
        bus.m0_req_i = 1'b1; bus.m0_we_i = 1'b0; bus.m0_addr_i = 32'd8;
        mid();
        check("rd_gnt_N", 32'(bus.m0_gnt_o), 32'd0);
        step();
        mid();
        check("rd_gnt_N1", 32'(bus.m0_gnt_o), 32'd1);
        check("rd_memrd", 32'(bus.mem_read_o), 32'd1);
        check("rd_memaddr", bus.mem_addr_o, 32'd8);
        step();
        bus.m0_req_i = 1'b0;
        mid();
        check("rd_rvalid", 32'(bus.m0_rvalid_o), 32'd1);
        check("rd_rdata", bus.m0_rdata_o, 32'h11223344);
        check("rd_err", 32'(bus.m0_err_o), 32'd0);
        check("rd_gnt_N2", 32'(bus.m0_gnt_o), 32'd0);
        step();

        // Tie after reset
        do_reset();
        bus.m0_req_i = 1'b1; bus.m0_we_i = 1'b0; bus.m0_addr_i = 32'd8;
        bus.m1_req_i = 1'b1; bus.m1_we_i = 1'b0; bus.m1_addr_i = 32'd12;
        mid();
        check("tie_gnt_N", 32'({bus.m0_gnt_o, bus.m1_gnt_o}), 32'd0);
        step();
        mid();
        check("tie_gnt_N1", 32'({bus.m0_gnt_o, bus.m1_gnt_o}), 32'b10);
        check("tie_addr_N1", bus.mem_addr_o, 32'd8);
        step();
        bus.m0_req_i = 1'b0;
        mid();
        check("tie_gnt_N2", 32'({bus.m0_gnt_o, bus.m1_gnt_o}), 32'b01);
        check("tie_rv0", 32'(bus.m0_rvalid_o), 32'd1);
        check("tie_rd0", bus.m0_rdata_o, 32'h11223344);
        check("tie_addr_N2", bus.mem_addr_o, 32'd12);
        step();
        bus.m1_req_i = 1'b0;
        mid();
        check("tie_rv1", 32'(bus.m1_rvalid_o), 32'd1);
        check("tie_rd1", bus.m1_rdata_o, 32'h12345678);
        check("tie_rv0_off", 32'(bus.m0_rvalid_o), 32'd0);
        check("tie_rd0_hold", bus.m0_rdata_o, 32'h11223344);
        step();

        // Fairness: both held, 8 grants alternate starting with m0
        bus.m0_req_i = 1'b1;
        bus.m1_req_i = 1'b1;
        mid();
        check("fair_idle", 32'({bus.m0_gnt_o, bus.m1_gnt_o}), 32'd0);
        step();
        for (int i = 0; i < 8; i++) begin
            if (i == 7)
                bus.m0_req_i = 1'b0;
            mid();
            check("fair_g0", 32'(bus.m0_gnt_o), 32'((i % 2) == 0));
            check("fair_g1", 32'(bus.m1_gnt_o), 32'((i % 2) == 1));
            if (i > 0)
                check("fair_rv0", 32'(bus.m0_rvalid_o), 32'((i % 2) == 1));
            if (bus.m0_gnt_o) n_g0++;
            if (bus.m1_gnt_o) n_g1++;
            step();
        end
        bus.m1_req_i = 1'b0;
        mid();
        check("fair_rv1_last", 32'(bus.m1_rvalid_o), 32'd1);
        check("fair_rd1_last", bus.m1_rdata_o, 32'h12345678);
        check("fair_n_g0", 32'(n_g0), 32'd4);
        check("fair_n_g1", 32'(n_g1), 32'd4);
        step();

        // Illegal accesses from m1
        ill_write(32'd30, 28, 32'hBFBEBDBC);
        ill_write(32'd5, 4, 32'hA7A6A5A4);

        // Reset during G0 write
        bus.m0_req_i = 1'b1; bus.m0_we_i = 1'b1;
        bus.m0_addr_i = 32'd0; bus.m0_wdata_i = 32'hDEADBEEF;
        step();
        rst = 1'b1;
        mid();
        check("rstop_gnt0", 32'(bus.m0_gnt_o), 32'd0);
        check("rstop_wr", 32'(bus.mem_write_o), 32'd0);
        check("rstop_rd", 32'(bus.mem_read_o), 32'd0);
        step();
        rst = 1'b0;
        bus.m0_req_i = 1'b0;
        mid();
        check("rstop_gnt", 32'({bus.m0_gnt_o, bus.m1_gnt_o}), 32'd0);
        check("rstop_rv", 32'({bus.m0_rvalid_o, bus.m1_rvalid_o}), 32'd0);
        check("rstop_err", 32'({bus.m0_err_o, bus.m1_err_o}), 32'd0);
        check("rstop_rd0", bus.m0_rdata_o, 32'h0);
        check("rstop_rd1", bus.m1_rdata_o, 32'h0);
        check("rstop_mem", memword(0), 32'hA3A2A1A0);
        step();

        // Back-to-back write then read from m0
        bus.m0_req_i = 1'b1; bus.m0_we_i = 1'b1;
        bus.m0_addr_i = 32'd4; bus.m0_wdata_i = 32'h89ABCDEF;
        step();
        mid();
        check("b2b_wgnt", 32'(bus.m0_gnt_o), 32'd1);
        check("b2b_wr", 32'(bus.mem_write_o), 32'd1);
        check("b2b_waddr", bus.mem_addr_o, 32'd4);
        check("b2b_wdata", bus.mem_wdata_o, 32'h89ABCDEF);
        step();
        bus.m0_we_i = 1'b0;
        mid();
        check("b2b_gap", 32'(bus.m0_gnt_o), 32'd0);
        check("b2b_wrv", 32'(bus.m0_rvalid_o), 32'd1);
        check("b2b_wrdata", bus.m0_rdata_o, 32'h0);
        check("b2b_mem", memword(4), 32'h89ABCDEF);
        step();
        mid();
        check("b2b_rgnt", 32'(bus.m0_gnt_o), 32'd1);
        check("b2b_rd", 32'(bus.mem_read_o), 32'd1);
        step();
        bus.m0_req_i = 1'b0;
        mid();
        check("b2b_rrv", 32'(bus.m0_rvalid_o), 32'd1);
        check("b2b_rdata", bus.m0_rdata_o, 32'h89ABCDEF);
        check("b2b_rerr", 32'(bus.m0_err_o), 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
